// File: rtl/restoring_divider_8bit_if.sv
// Purpose : start/done handshake and operand/result bus of the restoring divider.
// Latency : none, wiring only.
// Backpres: start is honoured only while busy is low; the requester watches busy/done.
interface restoring_divider_8bit_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/restoring_divider_8bit.sv
// Purpose : unsigned restoring shift-subtract divider, one quotient bit per clock.
// Latency : done in the cycle after the WIDTH-th edge past the accepting edge; divide-by-zero after 1 edge.
// Backpres: start is ignored while busy (CALC); accepted again in the DONE cycle for back-to-back use.
module restoring_divider_8bit #(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   restoring_divider_8bit_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_wq;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rmdr;
   logic             r_dbz;

   logic             w_accept;
   logic             w_last;
   logic [2*WIDTH-1:0] w_shift;
   logic [WIDTH-1:0] w_rem_sh;
   logic [WIDTH-1:0] w_wq_sh;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_rem_nx;
   logic [WIDTH-1:0] w_wq_nx;

   // A new request is taken whenever no iteration is running (IDLE or DONE).
   assign w_accept = (r_state != S_CALC) && bus.start;
   assign w_last   = (r_cnt == CW'(WIDTH - 1));

   // One restoring step. After k steps the partial remainder is below 2^k, so
   // the WIDTH-bit shifted remainder never loses its top bit.
   assign w_shift  = {r_rem, r_wq} << 1;
   assign w_rem_sh = w_shift[2*WIDTH-1:WIDTH];
   assign w_wq_sh  = w_shift[WIDTH-1:0];
   assign w_trial  = {1'b0, w_rem_sh} - {1'b0, r_div};
   assign w_rem_nx = w_trial[WIDTH] ? w_rem_sh : w_trial[WIDTH-1:0];
   assign w_wq_nx  = {w_wq_sh[WIDTH-1:1], ~w_trial[WIDTH]};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state: zero divisor skips straight to DONE, otherwise iterate WIDTH times.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               w_next = (bus.divisor == '0) ? S_DONE : S_CALC;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_CALC: begin
            if (w_last) begin
               w_next = S_DONE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Operand capture, iteration, and result load; results change only on entry to DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_rem  <= '0;
         r_wq   <= '0;
         r_div  <= '0;
         r_quot <= '0;
         r_rmdr <= '0;
         r_dbz  <= 1'b0;
      end else if (w_accept) begin
         r_cnt <= '0;
         r_rem <= '0;
         r_wq  <= bus.dividend;
         r_div <= bus.divisor;
         if (bus.divisor == '0) begin
            r_quot <= '1;
            r_rmdr <= bus.dividend;
            r_dbz  <= 1'b1;
         end
      end else if (r_state == S_CALC) begin
         r_cnt <= r_cnt + CW'(1);
         r_rem <= w_rem_nx;
         r_wq  <= w_wq_nx;
         if (w_last) begin
            r_quot <= w_wq_nx;
            r_rmdr <= w_rem_nx;
            r_dbz  <= 1'b0;
         end
      end
   end

   assign bus.busy        = (r_state == S_CALC);
   assign bus.done        = (r_state == S_DONE);
   assign bus.quotient    = r_quot;
   assign bus.remainder   = r_rmdr;
   assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_restoring_divider_8bit.sv
// Purpose : directed vectors for the restoring divider, checked against a plain-arithmetic model every cycle.
// Latency : measures edges from acceptance to done and busy-high cycles per operation.
// Backpres: exercises start while busy, start held across done, and async reset mid-operation.
module tb_restoring_divider_8bit;
   localparam int W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   restoring_divider_8bit_if #(.WIDTH(W)) bus ();

   restoring_divider_8bit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   function automatic void chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Behavioural model: result by / and %, timing as a busy countdown.
   int         m_cnt  = 0;
   bit         m_done = 1'b0;
   bit         m_dbz  = 1'b0;
   logic [7:0] m_q    = '0;
   logic [7:0] m_r    = '0;
   logic [7:0] p_q    = '0;
   logic [7:0] p_r    = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt = 0; m_done = 1'b0; m_dbz = 1'b0; m_q = '0; m_r = '0;
      end else if (m_cnt > 0) begin
         m_cnt  = m_cnt - 1;
         m_done = (m_cnt == 0);
         if (m_cnt == 0) begin
            m_q = p_q; m_r = p_r; m_dbz = 1'b0;
         end
      end else if (bus.start) begin
         if (bus.divisor == 0) begin
            m_q = 8'hFF; m_r = bus.dividend; m_dbz = 1'b1; m_done = 1'b1;
         end else begin
            p_q    = bus.dividend / bus.divisor;
            p_r    = bus.dividend % bus.divisor;
            m_cnt  = W;
            m_done = 1'b0;
         end
      end else begin
         m_done = 1'b0;
      end
   end

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      chk("busy", int'(bus.busy), int'(m_cnt > 0));
      chk("done", int'(bus.done), int'(m_done));
      chk("quotient", int'(bus.quotient), int'(m_q));
      chk("remainder", int'(bus.remainder), int'(m_r));
      chk("div_by_zero", int'(bus.div_by_zero), int'(m_dbz));
   end

   task automatic op_start(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Counts edges until done is seen and cycles with busy high; bounded.
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = int'(bus.busy);
      if (!bus.done) begin
         while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) break;
            if (bus.busy) bcnt++;
         end
      end
      chk("done_seen", int'(bus.done), 1);
   endtask

   task automatic check_result(input int eq, input int er, input int edbz);
      chk("lit_q", int'(bus.quotient), eq);
      chk("lit_r", int'(bus.remainder), er);
      chk("lit_dbz", int'(bus.div_by_zero), edbz);
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input int eq, input int er, input int edbz,
                         input int elat, input int ebusy);
      int lat, bc;
      op_start(a, b);
      wait_done(lat, bc);
      chk("latency", lat, elat);
      chk("busy_cycles", bc, ebusy);
      check_result(eq, er, edbz);
   endtask

   // Hand-computed vectors: dividend, divisor, quotient, remainder.
   int tv_a [6] = '{100, 255,   5, 255, 0, 9};
   int tv_b [6] = '{  7,   1,   9, 255, 3, 2};
   int tv_q [6] = '{ 14, 255,   0,   1, 0, 4};
   int tv_r [6] = '{  2,   0,   5,   0, 0, 1};

   initial begin
      int lat, bc;
      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;

      // Reset values.
      #1;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      check_result(0, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Normal divisions, including dividend 0 and extremes.
      for (int i = 0; i < 5; i++) begin
         run_op(8'(tv_a[i]), 8'(tv_b[i]), tv_q[i], tv_r[i], 0, 8, 8);
      end

      // Divide by zero, then a normal op clears the flag.
      run_op(8'd200, 8'd0, 255, 200, 1, 0, 0);
      run_op(8'd10, 8'd3, 3, 1, 0, 8, 8);

      // Start pulse during CALC cycle 3 is ignored.
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(lat, bc);
      chk("ignored_lat", lat, 5);
      check_result(14, 2, 0);

      // Start held across done: second op taken in the DONE cycle.
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
      @(negedge clk);
      bus.dividend = 8'd10; bus.divisor = 8'd3;
      wait_done(lat, bc);
      chk("b2b_lat1", lat, 8);
      chk("b2b_busy1", bc, 8);
      check_result(14, 2, 0);
      @(posedge clk); #1;
      chk("b2b_no_gap", int'(bus.busy), 1);
      bus.start = 1'b0;
      wait_done(lat, bc);
      chk("b2b_lat2", lat, 8);
      check_result(3, 1, 0);

      // Async reset mid-CALC aborts, then a fresh op works.
      op_start(8'd100, 8'd7);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_done", int'(bus.done), 0);
      check_result(0, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("abort_no_done", int'(bus.done), 0);
      end
      run_op(8'(tv_a[5]), 8'(tv_b[5]), tv_q[5], tv_r[5], 0, 8, 8);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
